stage_decode: RTL
=================

Name: stage_decode

Overview:
- Decode stage directly downstream of the fetch stage.
- Each cycle it consumes fetch's pc_out/inst_word pair, decodes fields, reads the 16x32 register file, and registers the result into the ID/EX pipeline outputs.
- Owns the register file (write port driven by writeback) and load-use hazard detection; drives the fetch stage's pc_stay.
- Honors flush (taken branch/jump, same signal as fetch's sel_pc) by inserting bubbles.

Parameters:
DBITS, 32, data/address width
REG_COUNT, 16, architectural registers (4-bit index)
HALT_WORD, 32'hdead, instruction word treated as halt (fetch holds PC on it)
STALL_CNT_BITS, 16, width of stall counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
pc_in  in  DBITS  PC of instruction presented by fetch (fetch pc_out)
inst_in  in  DBITS  instruction word from fetch
flush  in  1  redirect from EX (same as fetch sel_pc); kills decoding instruction
wb_en  in  1  register-file write enable
wb_rd  in  4  write index
wb_data  in  DBITS  write data
pc_stay  out  1  hold fetch PC (load-use stall); combinational
id_valid  out  1  ID/EX slot holds a real instruction
id_pc  out  DBITS  PC of instruction
id_opcode  out  4  inst[31:28]
id_rd  out  4  inst[27:24]
id_rs1_val  out  DBITS  operand 1
id_rs2_val  out  DBITS  operand 2
id_imm  out  DBITS  sign-extended inst[15:0]
id_rd_we  out  1  instruction writes rd
id_mem_read  out  1  instruction is a load
id_mem_write  out  1  instruction is a store
stall_count  out  STALL_CNT_BITS  saturating count of hazard-stall cycles

Behaviour:
- Encoding: opcode [31:28], rd [27:24], rs1 [23:20], rs2 [19:16], imm [15:0].
- Opcode classes:
  - 0 ALU-R: reads rs1,rs2; writes rd
  - 8 ALU-I: reads rs1; writes rd
  - 9 LW: reads rs1; writes rd; mem_read
  - 5 SW: reads rs1,rs2; mem_write
  - 2 BR: reads rs1,rs2
  - B JAL: reads rs1; writes rd
  - Any other opcode: valid, no reads, no writes, no memory access.
- Register file: 16 x DBITS, written at posedge when wb_en. No hardwired zero register.
- Read bypass: if wb_en && wb_rd == source index, the operand is wb_data in the same cycle.
- Hazard (combinational):
  - hazard = id_valid && id_mem_read && id_rd_we && incoming instruction reads id_rd (via rs1 or rs2, per its class).
  - pc_stay = hazard && !flush.
- Priority at posedge: reset > flush > hazard > halt > normal.
  - reset low: all outputs 0 (id_valid=0, id_pc=0, id_* fields=0, stall_count=0); all registers cleared to 0.
  - flush: id_valid=0 and all control bits (rd_we, mem_read, mem_write) = 0. Data fields don't-care; implement as 0.
  - hazard: bubble as above. Fetch holds, so the same instruction is re-decoded next cycle with the load now past decode. stall_count += 1, saturating at all-ones.
  - inst_in == HALT_WORD: bubble; no stall count.
  - normal: id_valid=1, all fields captured from decode/regfile.
- Latency: one cycle from fetch pair to ID/EX outputs.
- Hazard clears after one stall cycle, since the bubble leaves id_valid=0.
- Reset mid-stall: pc_stay drops during reset because id_valid=0.

Test Plan:
- Reset low 2 cycles, with inst_in=ALU-R → all outputs 0, pc_stay=0. Release reset → next cycle id_valid=1.
- Writeback r3=0x1234, r4=0x10 in earlier cycles; decode 0x0_5_3_4_0000 at pc 0x40 → next cycle id_pc=0x40, rs1_val=0x1234, rs2_val=0x10, id_rd=5, id_rd_we=1.
- wb_en with wb_rd=7, wb_data=0xCAFE in the same cycle as decoding ALU-I rs1=7, imm=0xFFFC → rs1_val=0xCAFE, id_imm=0xFFFFFFFC.
- LW r2 followed by ALU-R reading r2 → pc_stay=1 for exactly one cycle; bubble issued; ALU-R issued the following cycle; stall_count=1.
- Same load-use pair with flush=1 during the hazard cycle → pc_stay=0, bubble, stall_count unchanged.
- inst_in=32'hdead held 3 cycles → id_valid=0 throughout, pc_stay=0. Force stall_count to all-ones via repeated hazards → stays 0xFFFF.

Source files
------------

// File: rtl/stage_decode_if.sv
`default_nettype none
// ============================================================================
//  Module   : stage_decode_if
//  Purpose  : Bundles the decode stage's fetch-side, writeback-side and
//             ID/EX-side signals into one interface.
//  Ports    : (interface signals)
//    pc_in, inst_in, flush       - instruction pair from fetch, EX redirect
//    wb_en, wb_rd, wb_data       - register-file write port from writeback
//    pc_stay                     - load-use hold back to fetch
//    id_*                        - ID/EX pipeline register outputs
//    stall_count                 - saturating hazard-stall counter
//  Modports : master - drives fetch/writeback inputs, observes decode outputs
//             slave  - the decode stage itself
//  Revision : 1.0 - initial release
// ============================================================================
interface stage_decode_if #(
  parameter int DBITS          = 32,
  parameter int STALL_CNT_BITS = 16
);

  // Fetch / EX side
  logic [DBITS-1:0]          pc_in;
  logic [DBITS-1:0]          inst_in;
  logic                      flush;
  logic                      pc_stay;

  // Writeback side
  logic                      wb_en;
  logic [3:0]                wb_rd;
  logic [DBITS-1:0]          wb_data;

  // ID/EX side
  logic                      id_valid;
  logic [DBITS-1:0]          id_pc;
  logic [3:0]                id_opcode;
  logic [3:0]                id_rd;
  logic [DBITS-1:0]          id_rs1_val;
  logic [DBITS-1:0]          id_rs2_val;
  logic [DBITS-1:0]          id_imm;
  logic                      id_rd_we;
  logic                      id_mem_read;
  logic                      id_mem_write;
  logic [STALL_CNT_BITS-1:0] stall_count;

  modport master (
    output pc_in, inst_in, flush, wb_en, wb_rd, wb_data,
    input  pc_stay, id_valid, id_pc, id_opcode, id_rd, id_rs1_val,
           id_rs2_val, id_imm, id_rd_we, id_mem_read, id_mem_write,
           stall_count
  );

  modport slave (
    input  pc_in, inst_in, flush, wb_en, wb_rd, wb_data,
    output pc_stay, id_valid, id_pc, id_opcode, id_rd, id_rs1_val,
           id_rs2_val, id_imm, id_rd_we, id_mem_read, id_mem_write,
           stall_count
  );

endinterface : stage_decode_if
`default_nettype wire

// File: rtl/stage_decode.sv
`default_nettype none
// ============================================================================
//  Module   : stage_decode
//  Purpose  : Decode stage sitting directly behind fetch. Splits the
//             instruction word into fields, reads the 16-entry register file
//             (with same-cycle writeback bypass), detects load-use hazards,
//             and registers the result into the ID/EX outputs.
//  Ports    :
//    clk    in  - clock
//    reset  in  - synchronous, active-low reset
//    bus    slave modport of stage_decode_if:
//      pc_in/inst_in   in  - instruction pair from fetch
//      flush           in  - redirect from EX, kills the decoding instruction
//      wb_en/rd/data   in  - register-file write port
//      pc_stay         out - combinational hold request to fetch
//      id_*            out - ID/EX pipeline register
//      stall_count     out - saturating count of load-use stall cycles
//  Revision : 1.0 - initial release
// ============================================================================
module stage_decode #(
  parameter int               DBITS          = 32,
  parameter int               REG_COUNT      = 16,
  parameter logic [DBITS-1:0] HALT_WORD      = DBITS'(32'hdead),
  parameter int               STALL_CNT_BITS = 16
) (
  input  logic          clk,
  input  logic          reset,
  stage_decode_if.slave bus
);

  // --------------------------------------------------------------------------
  // Opcode classes
  // --------------------------------------------------------------------------
  localparam logic [3:0] c_op_alu_r = 4'h0;
  localparam logic [3:0] c_op_alu_i = 4'h8;
  localparam logic [3:0] c_op_lw    = 4'h9;
  localparam logic [3:0] c_op_sw    = 4'h5;
  localparam logic [3:0] c_op_br    = 4'h2;
  localparam logic [3:0] c_op_jal   = 4'hB;

  localparam logic [STALL_CNT_BITS-1:0] c_stall_one = STALL_CNT_BITS'(1);

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [DBITS-1:0]          r_rf [REG_COUNT];

  logic                      r_id_valid;
  logic [DBITS-1:0]          r_id_pc;
  logic [3:0]                r_id_opcode;
  logic [3:0]                r_id_rd;
  logic [DBITS-1:0]          r_id_rs1_val;
  logic [DBITS-1:0]          r_id_rs2_val;
  logic [DBITS-1:0]          r_id_imm;
  logic                      r_id_rd_we;
  logic                      r_id_mem_read;
  logic                      r_id_mem_write;
  logic [STALL_CNT_BITS-1:0] r_stall_count;

  // --------------------------------------------------------------------------
  // Field extraction
  // --------------------------------------------------------------------------
  logic [3:0]       w_opcode;
  logic [3:0]       w_rd;
  logic [3:0]       w_rs1;
  logic [3:0]       w_rs2;
  logic [DBITS-1:0] w_imm;

  assign w_opcode = bus.inst_in[31:28];
  assign w_rd     = bus.inst_in[27:24];
  assign w_rs1    = bus.inst_in[23:20];
  assign w_rs2    = bus.inst_in[19:16];
  assign w_imm    = {{(DBITS-16){bus.inst_in[15]}}, bus.inst_in[15:0]};

  // --------------------------------------------------------------------------
  // Class decode
  // --------------------------------------------------------------------------
  logic w_reads_rs1;
  logic w_reads_rs2;
  logic w_writes_rd;
  logic w_mem_read;
  logic w_mem_write;

  always_comb begin
    w_reads_rs1 = 1'b0;
    w_reads_rs2 = 1'b0;
    w_writes_rd = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    case (w_opcode)
      c_op_alu_r: begin
        w_reads_rs1 = 1'b1;
        w_reads_rs2 = 1'b1;
        w_writes_rd = 1'b1;
      end
      c_op_alu_i: begin
        w_reads_rs1 = 1'b1;
        w_writes_rd = 1'b1;
      end
      c_op_lw: begin
        w_reads_rs1 = 1'b1;
        w_writes_rd = 1'b1;
        w_mem_read  = 1'b1;
      end
      c_op_sw: begin
        w_reads_rs1 = 1'b1;
        w_reads_rs2 = 1'b1;
        w_mem_write = 1'b1;
      end
      c_op_br: begin
        w_reads_rs1 = 1'b1;
        w_reads_rs2 = 1'b1;
      end
      c_op_jal: begin
        w_reads_rs1 = 1'b1;
        w_writes_rd = 1'b1;
      end
      default: ;  // valid instruction with no register or memory activity
    endcase
  end

  // --------------------------------------------------------------------------
  // Register read with writeback bypass. An operand the class does not read
  // is presented as zero so EX never sees stale register contents.
  // --------------------------------------------------------------------------
  logic [DBITS-1:0] w_rs1_val;
  logic [DBITS-1:0] w_rs2_val;

  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (w_reads_rs1) begin
      w_rs1_val = (bus.wb_en && (bus.wb_rd == w_rs1)) ? bus.wb_data : r_rf[w_rs1];
    end
    if (w_reads_rs2) begin
      w_rs2_val = (bus.wb_en && (bus.wb_rd == w_rs2)) ? bus.wb_data : r_rf[w_rs2];
    end
  end

  // --------------------------------------------------------------------------
  // Load-use hazard: the load in ID/EX has not produced its data yet, so an
  // instruction that sources its rd must wait one cycle. The bubble inserted
  // for the stall clears id_valid, which removes the hazard on the retry.
  // --------------------------------------------------------------------------
  logic w_hazard;
  logic w_is_halt;
  logic w_stall_sat;

  assign w_hazard = r_id_valid && r_id_mem_read && r_id_rd_we &&
                    ((w_reads_rs1 && (w_rs1 == r_id_rd)) ||
                     (w_reads_rs2 && (w_rs2 == r_id_rd)));

  assign w_is_halt   = (bus.inst_in == HALT_WORD);
  assign w_stall_sat = &r_stall_count;

  // A flushed instruction is being discarded anyway, so fetch must not hold.
  assign bus.pc_stay = w_hazard && !bus.flush;

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_rf[i] <= '0;
      end
    end else if (bus.wb_en) begin
      r_rf[bus.wb_rd] <= bus.wb_data;
    end
  end

  // --------------------------------------------------------------------------
  // ID/EX pipeline register. Priority: reset > flush > hazard > halt > issue.
  // Every non-issue case loads an all-zero bubble.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_id_valid     <= 1'b0;
      r_id_pc        <= '0;
      r_id_opcode    <= '0;
      r_id_rd        <= '0;
      r_id_rs1_val   <= '0;
      r_id_rs2_val   <= '0;
      r_id_imm       <= '0;
      r_id_rd_we     <= 1'b0;
      r_id_mem_read  <= 1'b0;
      r_id_mem_write <= 1'b0;
      r_stall_count  <= '0;
    end else if (bus.flush || w_hazard || w_is_halt) begin
      r_id_valid     <= 1'b0;
      r_id_pc        <= '0;
      r_id_opcode    <= '0;
      r_id_rd        <= '0;
      r_id_rs1_val   <= '0;
      r_id_rs2_val   <= '0;
      r_id_imm       <= '0;
      r_id_rd_we     <= 1'b0;
      r_id_mem_read  <= 1'b0;
      r_id_mem_write <= 1'b0;
      // Only a genuine load-use stall counts; flush wins over the hazard.
      if (!bus.flush && w_hazard && !w_stall_sat) begin
        r_stall_count <= r_stall_count + c_stall_one;
      end
    end else begin
      r_id_valid     <= 1'b1;
      r_id_pc        <= bus.pc_in;
      r_id_opcode    <= w_opcode;
      r_id_rd        <= w_rd;
      r_id_rs1_val   <= w_rs1_val;
      r_id_rs2_val   <= w_rs2_val;
      r_id_imm       <= w_imm;
      r_id_rd_we     <= w_writes_rd;
      r_id_mem_read  <= w_mem_read;
      r_id_mem_write <= w_mem_write;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.id_valid     = r_id_valid;
  assign bus.id_pc        = r_id_pc;
  assign bus.id_opcode    = r_id_opcode;
  assign bus.id_rd        = r_id_rd;
  assign bus.id_rs1_val   = r_id_rs1_val;
  assign bus.id_rs2_val   = r_id_rs2_val;
  assign bus.id_imm       = r_id_imm;
  assign bus.id_rd_we     = r_id_rd_we;
  assign bus.id_mem_read  = r_id_mem_read;
  assign bus.id_mem_write = r_id_mem_write;
  assign bus.stall_count  = r_stall_count;

endmodule : stage_decode
`default_nettype wire
